vga_plot_engine: RTL and testbench
==================================

Name: vga_plot_engine

Overview:
- Responder end of the control path's VGA plot interface.
- Accepts plot requests carrying 16-bit color and coordinate register values. Converts each request into one framebuffer pixel write.
- Accepts a clear-screen request, which sweeps every pixel with a fixed color.
- Sits between the datapath register file outputs and the framebuffer write port of the VGA adapter.

Parameters:
- WIDTH, 160, visible pixel columns.
- HEIGHT, 120, visible pixel rows.
- X_BITS, 8, width of fb_x; must satisfy 2^X_BITS >= WIDTH.
- Y_BITS, 7, width of fb_y; must satisfy 2^Y_BITS >= HEIGHT.
- COLOR_BITS, 3, framebuffer color width.
- CLEAR_COLOR, 0, color written during a clear sweep.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- resetn  input  1  asynchronous active-low reset.
- plot  input  1  plot request level; a rising edge is a request.
- clear_req  input  1  clear request level; a rising edge is a request.
- color  input  16  color register value; bits [COLOR_BITS-1:0] are used.
- coord  input  16  coordinate register value; x = coord[15:8], y = coord[7:0].
- fb_x  output  X_BITS  framebuffer write column.
- fb_y  output  Y_BITS  framebuffer write row.
- fb_color  output  COLOR_BITS  framebuffer write data.
- fb_write  output  1  framebuffer write enable, one pixel per cycle high.
- busy  output  1  engine is not in IDLE.
- done  output  1  one-cycle pulse when a plot or clear completes.
- range_error  output  1  one-cycle pulse when a plot is dropped for out-of-range coordinates.
- overrun  output  1  sticky flag: a pending plot was overwritten; cleared only by reset.

Behaviour:
- Reset, asynchronous: state = IDLE. All outputs are 0; plot_q, clear_q, pending, sweep counters and latches are 0.
- Edge detect:
  - plot_edge = plot & ~plot_q; clear_edge = clear_req & ~clear_q.
  - plot_q and clear_q are registered every cycle.
- Request latch: on plot_edge, in any state, capture x = coord[15:8], y = coord[7:0], c = color[COLOR_BITS-1:0].
  - In IDLE the captured values go to the active latch.
  - In any other state they go to the single-deep pending buffer and pending is set.
  - If pending is already 1, the buffer is overwritten and overrun is set.
- States:
  - IDLE:
    - clear_edge has priority → CLEAR, with sweep x = 0, y = 0.
    - Else plot_edge → range check on the fresh request.
    - Else if pending → clear pending, range check on the buffered request.
    - Range check: x < WIDTH and y < HEIGHT → PLOT. Otherwise pulse range_error the next cycle and stay in IDLE; done is not pulsed.
    - A simultaneous clear_edge and plot_edge in IDLE: the plot goes to the pending buffer.
  - PLOT: fb_write = 1 with the latched x/y/c for exactly one cycle → ACK.
  - ACK: done = 1 for one cycle → IDLE.
  - CLEAR:
    - fb_write = 1, fb_color = CLEAR_COLOR, fb_x/fb_y = sweep counters.
    - x increments each cycle; at x == WIDTH-1, x wraps to 0 and y increments.
    - At x == WIDTH-1 and y == HEIGHT-1 the last write occurs → ACK.
    - clear_edge during CLEAR is ignored; it does not restart the sweep.
- Latency:
  - Plot edge sampled at posedge N → fb_write high during cycle N+1 → done during cycle N+2. busy is high from N+1 through N+2.
  - Clear: exactly WIDTH*HEIGHT consecutive fb_write cycles, then done.
- fb_x, fb_y and fb_color hold their last driven value when fb_write = 0.
- Coordinates are compared as unsigned. Truncation to X_BITS/Y_BITS happens only after the range check passes.
- Reset mid-sweep or mid-plot aborts immediately: fb_write = 0 and pending is discarded.

Test Plan:
- Plot in range: coord = 16'h0A05, color = 16'h0006, plot rises → one cycle with fb_write = 1, fb_x = 10, fb_y = 5, fb_color = 6; done the following cycle; busy for exactly 2 cycles.
- Out of range: coord = 16'hA000 (x = 160) → no fb_write, range_error pulses once, busy stays 0; plot = 16'h9F77 (x = 159, y = 119) is accepted.
- Clear sweep: clear_req rises → 19200 consecutive fb_write cycles. First write (0,0), write 160 is (0,1), last write (159,119), all with color 0; then done.
- Pending during clear: plot edge with coord 16'h0102 at sweep cycle 100 → after the clear done, fb_write at (1,2) within 2 cycles of returning to IDLE. A second plot edge during the same clear sets overrun, and only the second coordinate is written.
- Level hold: plot held high for 20 cycles → exactly one fb_write. Simultaneous clear_edge and plot_edge in IDLE → full clear, then the plot pixel written afterwards.
- Async reset mid-clear at sweep (50,3) → fb_write, busy, done and overrun drop to 0 without a clock edge. After release the engine stays idle until a new edge arrives.

Source files
------------

// File: rtl/vga_plot_engine_if.sv
// Plot/clear request inputs and framebuffer write port of the VGA plot engine.
// The master side drives requests; the slave side is the engine.
interface vga_plot_engine_if #(
    parameter int unsigned X_BITS     = 8,
    parameter int unsigned Y_BITS     = 7,
    parameter int unsigned COLOR_BITS = 3
);
    logic                  plot;
    logic                  clear_req;
    logic [15:0]           color;
    logic [15:0]           coord;
    logic [X_BITS-1:0]     fb_x;
    logic [Y_BITS-1:0]     fb_y;
    logic [COLOR_BITS-1:0] fb_color;
    logic                  fb_write;
    logic                  busy;
    logic                  done;
    logic                  range_error;
    logic                  overrun;

    modport master (
        output plot, clear_req, color, coord,
        input  fb_x, fb_y, fb_color, fb_write, busy, done, range_error, overrun
    );

    modport slave (
        input  plot, clear_req, color, coord,
        output fb_x, fb_y, fb_color, fb_write, busy, done, range_error, overrun
    );
endinterface

// File: rtl/vga_plot_engine.sv
// Turns edge-triggered plot/clear requests into framebuffer pixel writes,
// with a single-deep pending buffer for plots that arrive while busy.
module vga_plot_engine #(
    parameter int unsigned           WIDTH       = 160,
    parameter int unsigned           HEIGHT      = 120,
    parameter int unsigned           X_BITS      = 8,
    parameter int unsigned           Y_BITS      = 7,
    parameter int unsigned           COLOR_BITS  = 3,
    parameter logic [COLOR_BITS-1:0] CLEAR_COLOR = '0
) (
    input logic              clock,
    input logic              resetn,
    vga_plot_engine_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLOT,
        S_ACK,
        S_CLEAR
    } state_t;

    state_t r_state;
    state_t w_next;

    logic r_plot_q;
    logic r_clear_q;
    logic w_plot_edge;
    logic w_clear_edge;

    logic [7:0]            w_new_x;
    logic [7:0]            w_new_y;
    logic [COLOR_BITS-1:0] w_new_c;
    logic                  w_unused;

    logic [X_BITS-1:0]     r_act_x;
    logic [Y_BITS-1:0]     r_act_y;
    logic [COLOR_BITS-1:0] r_act_c;

    logic [7:0]            r_pend_x;
    logic [7:0]            r_pend_y;
    logic [COLOR_BITS-1:0] r_pend_c;
    logic                  r_pend_valid;
    logic                  r_overrun;
    logic                  r_range_err;

    logic [X_BITS-1:0]     r_sx;
    logic [Y_BITS-1:0]     r_sy;
    logic                  w_sweep_last;
    logic                  w_row_last;

    logic [X_BITS-1:0]     r_hold_x;
    logic [Y_BITS-1:0]     r_hold_y;
    logic [COLOR_BITS-1:0] r_hold_c;

    logic [7:0]            w_req_x;
    logic [7:0]            w_req_y;
    logic [COLOR_BITS-1:0] w_req_c;
    logic                  w_check;
    logic                  w_in_range;
    logic                  w_pend_take;
    logic                  w_start_clear;
    logic                  w_to_pend;

    assign w_plot_edge  = bus.plot & ~r_plot_q;
    assign w_clear_edge = bus.clear_req & ~r_clear_q;

    assign w_new_x  = bus.coord[15:8];
    assign w_new_y  = bus.coord[7:0];
    assign w_new_c  = bus.color[COLOR_BITS-1:0];
    assign w_unused = ^bus.color[15:COLOR_BITS];

    assign w_row_last   = (r_sx == X_BITS'(WIDTH - 1));
    assign w_sweep_last = w_row_last && (r_sy == Y_BITS'(HEIGHT - 1));

    // A plot edge goes straight to the active latch only when IDLE can act on
    // it this cycle; a coincident clear wins and the plot waits in the buffer.
    assign w_to_pend = w_plot_edge && !((r_state == S_IDLE) && !w_clear_edge);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_plot_q  <= 1'b0;
            r_clear_q <= 1'b0;
        end else begin
            r_plot_q  <= bus.plot;
            r_clear_q <= bus.clear_req;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_req_x       = w_new_x;
        w_req_y       = w_new_y;
        w_req_c       = w_new_c;
        w_check       = 1'b0;
        w_pend_take   = 1'b0;
        w_start_clear = 1'b0;
        w_in_range    = (32'(w_req_x) < WIDTH) && (32'(w_req_y) < HEIGHT);
        case (r_state)
            S_IDLE: begin
                if (w_clear_edge) begin
                    w_next        = S_CLEAR;
                    w_start_clear = 1'b1;
                end else if (w_plot_edge) begin
                    w_check = 1'b1;
                end else if (r_pend_valid) begin
                    w_check     = 1'b1;
                    w_pend_take = 1'b1;
                    w_req_x     = r_pend_x;
                    w_req_y     = r_pend_y;
                    w_req_c     = r_pend_c;
                end
                w_in_range = (32'(w_req_x) < WIDTH) && (32'(w_req_y) < HEIGHT);
                if (w_check && w_in_range) begin
                    w_next = S_PLOT;
                end
            end
            S_PLOT:  w_next = S_ACK;
            S_ACK:   w_next = S_IDLE;
            S_CLEAR: begin
                if (w_sweep_last) begin
                    w_next = S_ACK;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_act_x      <= '0;
            r_act_y      <= '0;
            r_act_c      <= '0;
            r_pend_x     <= '0;
            r_pend_y     <= '0;
            r_pend_c     <= '0;
            r_pend_valid <= 1'b0;
            r_overrun    <= 1'b0;
            r_range_err  <= 1'b0;
        end else begin
            // Truncation happens only here, after the full-width range check.
            if (w_check) begin
                r_act_x <= X_BITS'(w_req_x);
                r_act_y <= Y_BITS'(w_req_y);
                r_act_c <= w_req_c;
            end
            if (w_to_pend) begin
                r_pend_x     <= w_new_x;
                r_pend_y     <= w_new_y;
                r_pend_c     <= w_new_c;
                r_pend_valid <= 1'b1;
                if (r_pend_valid) begin
                    r_overrun <= 1'b1;
                end
            end else if (w_pend_take) begin
                r_pend_valid <= 1'b0;
            end
            r_range_err <= w_check && !w_in_range;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_sx     <= '0;
            r_sy     <= '0;
            r_hold_x <= '0;
            r_hold_y <= '0;
            r_hold_c <= '0;
        end else begin
            if (w_start_clear) begin
                r_sx <= '0;
                r_sy <= '0;
            end else if (r_state == S_CLEAR) begin
                if (w_row_last) begin
                    r_sx <= '0;
                    r_sy <= r_sy + 1'b1;
                end else begin
                    r_sx <= r_sx + 1'b1;
                end
            end
            if (r_state == S_PLOT) begin
                r_hold_x <= r_act_x;
                r_hold_y <= r_act_y;
                r_hold_c <= r_act_c;
            end else if (r_state == S_CLEAR) begin
                r_hold_x <= r_sx;
                r_hold_y <= r_sy;
                r_hold_c <= CLEAR_COLOR;
            end
        end
    end

    always_comb begin
        bus.fb_write = 1'b0;
        bus.fb_x     = r_hold_x;
        bus.fb_y     = r_hold_y;
        bus.fb_color = r_hold_c;
        case (r_state)
            S_PLOT: begin
                bus.fb_write = 1'b1;
                bus.fb_x     = r_act_x;
                bus.fb_y     = r_act_y;
                bus.fb_color = r_act_c;
            end
            S_CLEAR: begin
                bus.fb_write = 1'b1;
                bus.fb_x     = r_sx;
                bus.fb_y     = r_sy;
                bus.fb_color = CLEAR_COLOR;
            end
            default: ;
        endcase
    end

    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = (r_state == S_ACK);
    assign bus.range_error = r_range_err;
    assign bus.overrun     = r_overrun;

endmodule

// File: tb/tb_vga_plot_engine.sv
// Directed bench for vga_plot_engine: expected pixel writes are queued as
// requests are driven and popped by a monitor whenever fb_write is seen.
module tb_vga_plot_engine;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;
    logic [17:0] exp_q[$];
    logic [17:0] mon_e;

    vga_plot_engine_if #(.X_BITS(8), .Y_BITS(7), .COLOR_BITS(3)) bus();

    vga_plot_engine #(
        .WIDTH(160),
        .HEIGHT(120),
        .X_BITS(8),
        .Y_BITS(7),
        .COLOR_BITS(3),
        .CLEAR_COLOR(3'd0)
    ) u_dut (
        .clock(clk),
        .resetn(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] px(input int x, input int y, input int c);
        return {8'(x), 7'(y), 3'(c)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_clear(input int count);
        for (int i = 0; i < count; i++) begin
            exp_q.push_back(px(i % 160, i / 160, 0));
        end
    endtask

    task automatic wait_done(input string tag, input int limit);
        int k = 0;
        while (bus.done !== 1'b1 && k < limit) begin
            tick();
            k++;
        end
        check(tag, 32'(bus.done), 32'd1);
    endtask

    task automatic sweep(input string tag, input int toggle_at);
        int n = 0;
        while (bus.fb_write === 1'b1 && n < 20000) begin
            n++;
            if (n == toggle_at) bus.clear_req = 1'b1;
            if (n == toggle_at + 1) bus.clear_req = 1'b0;
            tick();
        end
        check({tag, "_len"}, 32'(n), 32'd19200);
        check({tag, "_done"}, 32'(bus.done), 32'd1);
    endtask

    // Scoreboard monitor: every write must have been predicted, in order.
    always @(negedge clk) begin
        if (bus.fb_write === 1'b1) begin
            check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("wr_pixel", 32'({bus.fb_x, bus.fb_y, bus.fb_color}), 32'(mon_e));
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw;
        bus.plot      = 1'b0;
        bus.clear_req = 1'b0;
        bus.color     = '0;
        bus.coord     = '0;
        rst_n         = 1'b0;
        repeat (3) tick();

        check("rst_write", 32'(bus.fb_write), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_rerr", 32'(bus.range_error), 32'd0);
        check("rst_ovr", 32'(bus.overrun), 32'd0);
        check("rst_pix", 32'({bus.fb_x, bus.fb_y, bus.fb_color}), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // In-range plot: write, then done, busy for two cycles
        exp_q.push_back(px(10, 5, 6));
        bus.coord = 16'h0A05;
        bus.color = 16'h0006;
        bus.plot  = 1'b1;
        tick();
        check("plot_write", 32'(bus.fb_write), 32'd1);
        check("plot_busy1", 32'(bus.busy), 32'd1);
        check("plot_nodone", 32'(bus.done), 32'd0);
        tick();
        check("plot_done", 32'(bus.done), 32'd1);
        check("plot_busy2", 32'(bus.busy), 32'd1);
        check("plot_wr_low", 32'(bus.fb_write), 32'd0);
        check("plot_hold", 32'({bus.fb_x, bus.fb_y, bus.fb_color}), 32'(px(10, 5, 6)));
        tick();
        check("plot_busy3", 32'(bus.busy), 32'd0);
        check("plot_done_low", 32'(bus.done), 32'd0);
        bus.plot = 1'b0;
        tick();

        // Out of range on x, then on y
        bus.coord = 16'hA000;
        bus.plot  = 1'b1;
        tick();
        check("rx_rerr", 32'(bus.range_error), 32'd1);
        check("rx_busy", 32'(bus.busy), 32'd0);
        check("rx_write", 32'(bus.fb_write), 32'd0);
        bus.plot = 1'b0;
        tick();
        check("rx_rerr_low", 32'(bus.range_error), 32'd0);
        check("rx_nodone", 32'(bus.done), 32'd0);
        bus.coord = 16'h0078;
        bus.plot  = 1'b1;
        tick();
        check("ry_rerr", 32'(bus.range_error), 32'd1);
        bus.plot = 1'b0;
        tick();
        check("ry_rerr_low", 32'(bus.range_error), 32'd0);

        // Largest legal coordinate, upper color bits ignored
        exp_q.push_back(px(159, 119, 7));
        bus.coord = 16'h9F77;
        bus.color = 16'hFFFF;
        bus.plot  = 1'b1;
        tick();
        check("max_rerr", 32'(bus.range_error), 32'd0);
        check("max_write", 32'(bus.fb_write), 32'd1);
        bus.plot = 1'b0;
        wait_done("max_done", 4);
        tick();

        // Level held high for 20 cycles gives a single write
        exp_q.push_back(px(33, 44, 2));
        bus.coord = 16'h212C;
        bus.color = 16'h0002;
        bus.plot  = 1'b1;
        nw = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.fb_write === 1'b1) nw++;
        end
        check("hold_writes", 32'(nw), 32'd1);
        bus.plot = 1'b0;
        tick();

        // Full clear sweep
        push_clear(19200);
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        sweep("clr1", -1);
        tick();

        // Plots during a clear: second overwrites the first and flags overrun
        push_clear(19200);
        exp_q.push_back(px(3, 4, 5));
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        repeat (99) tick();
        bus.coord = 16'h0102;
        bus.color = 16'h0001;
        bus.plot  = 1'b1;
        tick();
        bus.plot = 1'b0;
        check("ovr_first", 32'(bus.overrun), 32'd0);
        check("clr2_busy", 32'(bus.busy), 32'd1);
        repeat (98) tick();
        bus.coord = 16'h0304;
        bus.color = 16'h0005;
        bus.plot  = 1'b1;
        tick();
        bus.plot = 1'b0;
        check("ovr_set", 32'(bus.overrun), 32'd1);
        wait_done("clr2_done", 20000);
        tick();
        check("pend_idle", 32'(bus.busy), 32'd0);
        tick();
        check("pend_write", 32'(bus.fb_write), 32'd1);
        tick();
        check("pend_done", 32'(bus.done), 32'd1);
        tick();

        // Simultaneous clear and plot edges; a re-trigger mid-sweep is ignored
        push_clear(19200);
        exp_q.push_back(px(7, 8, 3));
        bus.coord     = 16'h0708;
        bus.color     = 16'h0003;
        bus.clear_req = 1'b1;
        bus.plot      = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        bus.plot      = 1'b0;
        sweep("clr3", 1000);
        tick();
        tick();
        check("simul_write", 32'(bus.fb_write), 32'd1);
        tick();
        check("simul_done", 32'(bus.done), 32'd1);
        check("ovr_sticky", 32'(bus.overrun), 32'd1);
        tick();

        // Asynchronous reset at sweep (50,3) with a plot pending
        push_clear(531);
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        repeat (100) tick();
        bus.coord = 16'h0909;
        bus.color = 16'h0004;
        bus.plot  = 1'b1;
        tick();
        bus.plot = 1'b0;
        repeat (429) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_write", 32'(bus.fb_write), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        check("arst_ovr", 32'(bus.overrun), 32'd0);
        check("arst_sb", 32'(exp_q.size()), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("arst_idle", 32'(bus.busy), 32'd0);

        // Engine still works after reset
        exp_q.push_back(px(2, 3, 1));
        bus.coord = 16'h0203;
        bus.color = 16'h0001;
        bus.plot  = 1'b1;
        tick();
        check("final_write", 32'(bus.fb_write), 32'd1);
        bus.plot = 1'b0;
        wait_done("final_done", 4);
        tick();
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
